div_result_stage: RTL and testbench
===================================

DIV_RESULT_STAGE -- requirements
Module: div_result_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 16, giving the divisor and remainder width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, giving the number of output buffer entries (power of two).
REQ-003 SHALL have port clk  input  1  the single clock, rising-edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  raw result from the divider array is valid this cycle.
REQ-006 SHALL have port in_mode  input  1  1 = quotient requested, 0 = remainder requested.
REQ-007 SHALL have port in_divisor  input  DATA_W  divisor that travelled with the operation.
REQ-008 SHALL have port raw_quotient  input  DATA_W+1  binary quotient from the array.
REQ-009 SHALL have port raw_remainder  input  DATA_W+1  two's-complement partial remainder, uncorrected.
REQ-010 SHALL have port in_ready  output  1  advisory issue permission to upstream.
REQ-011 SHALL have port out_valid  output  1  final_output holds a result.
REQ-012 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-013 SHALL have port final_output  output  DATA_W+1  corrected quotient or remainder.
REQ-014 SHALL have port out_error  output  1  result came from a divide-by-zero.
REQ-015 SHALL have port overflow  output  1  sticky flag: a result was dropped.
REQ-016 SHALL have port clr_overflow  input  1  synchronous clear of overflow.
REQ-017 SHALL have port count  output  3  current number of buffered results.

Function
REQ-018 SHALL register one correction stage (s1) on every clk edge where in_valid=1; s1_valid follows in_valid.
REQ-019 SHALL compute the corrected remainder as raw_remainder + {0,in_divisor} when raw_remainder[DATA_W]=1, else raw_remainder, truncated to DATA_W bits and zero-extended to DATA_W+1.
REQ-020 SHALL pass raw_quotient unchanged.
REQ-021 SHALL select the quotient when in_mode=1, else the corrected remainder.
REQ-022 SHALL, when in_divisor=0, force the result to all ones (17'h1FFFF at default) and set the error bit, regardless of mode.
REQ-023 SHALL write {error, result} from s1 into the FIFO on the edge following s1 capture; end-to-end latency into an empty FIFO is 2 cycles (input in cycle N, out_valid high in cycle N+2).
REQ-024 SHALL present the FIFO head on final_output/out_error with out_valid=1 whenever count>0, holding it stable while out_ready=0.
REQ-025 SHALL pop the head on any edge where out_valid=1 and out_ready=1.
REQ-026 SHALL, when the FIFO is full and a write and a pop coincide, perform both, keeping count at FIFO_DEPTH and leaving overflow unchanged.
REQ-027 SHALL, when the FIFO is full and a write occurs without a pop, drop the new entry and set overflow.
REQ-028 SHALL hold overflow until clr_overflow=1 or reset; a set and a clear in the same cycle SHALL leave overflow set.
REQ-029 SHALL drive in_ready = (count + s1_valid) < FIFO_DEPTH, combinationally.
REQ-030 SHALL wrap the read and write pointers modulo FIFO_DEPTH and preserve result order.

Reset
REQ-031 SHALL, on reset=0, asynchronously clear s1_valid, the pointers, count, and overflow, and hold final_output=0, out_error=0, out_valid=0, in_ready=1.
REQ-032 SHALL discard all in-flight and buffered results when reset is asserted mid-operation; no partial output SHALL appear after release.

Structure
REQ-033 SHALL take DATA_W, FIFO_DEPTH and the DIV0 result constant from the shared package div_pkg.
REQ-034 SHALL implement the buffer as sub-module div_result_fifo, containing the storage, the pointers, count and full/empty.

Verification
REQ-035 SHALL test: in_divisor=7, raw_remainder=17'h1FFFD, mode=0 -> final_output=17'h00004 and out_error=0, with out_valid in cycle N+2.
REQ-036 SHALL test: mode=1, raw_quotient=17'h00010, in_divisor=3 -> final_output=17'h00010.
REQ-037 SHALL test: in_divisor=0, mode=0 -> final_output=17'h1FFFF and out_error=1.
REQ-038 SHALL test: out_ready=0 with 5 back-to-back inputs -> count=4, overflow=1, the 5th result lost; the 4 results then drain in order.
REQ-039 SHALL test: FIFO full, out_ready=1, in_valid=1 -> count stays 4 and overflow stays 0.
REQ-040 SHALL test: reset=0 mid-drain -> out_valid=0, count=0 and overflow=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/div_pkg.sv
// Shared constants for the divider result stage.
// Imported by the stage and its output buffer.
package div_pkg;

  localparam int DIV_DATA_W     = 16;
  localparam int DIV_FIFO_DEPTH = 4;

  // Result reported for a divide-by-zero, either mode
  localparam logic [DIV_DATA_W:0] DIV0_RESULT = '1;

endpackage

// File: rtl/div_result_fifo.sv
// Output buffer for corrected divider results.
// Storage, wrapping pointers, occupancy and full/empty.
module div_result_fifo
  import div_pkg::*;
#(
  parameter int W     = DIV_DATA_W + 2,
  parameter int DEPTH = DIV_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign pop   = rd_en & ~empty;
  // A write into a full buffer lands only if the head leaves this edge
  assign push  = wr_en & (~full | pop);

  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/div_result_stage.sv
// Final divider stage: remainder correction, mode select,
// divide-by-zero override and a buffered valid/ready output.
module div_result_stage
  import div_pkg::*;
#(
  parameter int DATA_W     = DIV_DATA_W,
  parameter int FIFO_DEPTH = DIV_FIFO_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic                         in_mode,
  input  logic [DATA_W-1:0]            in_divisor,
  input  logic [DATA_W:0]              raw_quotient,
  input  logic [DATA_W:0]              raw_remainder,
  output logic                         in_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W:0]              final_output,
  output logic                         out_error,
  output logic                         overflow,
  input  logic                         clr_overflow,
  output logic [$clog2(FIFO_DEPTH):0]  count
);

  localparam int EW = DATA_W + 2;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DATA_W:0] DIV0 = {(DATA_W+1){DIV0_RESULT[0]}};

  logic [DATA_W-1:0] rem_lo;
  logic [DATA_W:0]   res;
  logic              div0;
  logic              s1_valid;
  logic [EW-1:0]     s1_data;
  logic [EW-1:0]     head;
  logic              empty;
  logic              full;
  logic              drop;
  logic [CW:0]       occ;

  always_comb begin
    rem_lo = raw_remainder[DATA_W-1:0];
    // Negative partial remainder: add the divisor back, keep low bits
    if (raw_remainder[DATA_W]) rem_lo = raw_remainder[DATA_W-1:0] + in_divisor;
    div0 = (in_divisor == '0);
    res  = in_mode ? raw_quotient : {1'b0, rem_lo};
    if (div0) res = DIV0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) s1_data <= {div0, res};
    end
  end

  div_result_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (s1_valid),
    .wr_data (s1_data),
    .rd_en   (out_ready),
    .rd_data (head),
    .empty   (empty),
    .full    (full),
    .count   (count)
  );

  assign out_valid = ~empty;
  assign {out_error, final_output} = empty ? '0 : head;

  assign drop = s1_valid & full & ~out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
    end
  end

  assign occ      = {1'b0, count} + {{CW{1'b0}}, s1_valid};
  assign in_ready = occ < (CW+1)'(FIFO_DEPTH);

endmodule

// File: tb/tb_div_result_stage.sv
// Directed bench for div_result_stage.
// Each scenario task drives vectors and checks hand-computed results.
module tb_div_result_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_mode = 1'b0;
  logic [15:0] in_divisor = '0;
  logic [16:0] raw_quotient = '0;
  logic [16:0] raw_remainder = '0;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [16:0] final_output;
  logic        out_error;
  logic        overflow;
  logic        clr_overflow = 1'b0;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  div_result_stage dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_mode       (in_mode),
    .in_divisor    (in_divisor),
    .raw_quotient  (raw_quotient),
    .raw_remainder (raw_remainder),
    .in_ready      (in_ready),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .final_output  (final_output),
    .out_error     (out_error),
    .overflow      (overflow),
    .clr_overflow  (clr_overflow),
    .count         (count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic m, input logic [15:0] d,
                      input logic [16:0] q, input logic [16:0] r);
    in_valid      = 1'b1;
    in_mode       = m;
    in_divisor    = d;
    raw_quotient  = q;
    raw_remainder = r;
  endtask

  task automatic pop();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_valid got %b want 0", out_valid);
    end
    checks++;
    if (count !== 3'd0) begin
      errors++; $display("FAIL rst_count got %0d want 0", count);
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL rst_ovf got %b want 0", overflow);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_ready got %b want 1", in_ready);
    end
    checks++;
    if (final_output !== 17'h0 || out_error !== 1'b0) begin
      errors++;
      $display("FAIL rst_out got %h/%b want 0/0", final_output, out_error);
    end
    @(negedge clk);
    reset = 1'b1;
    step();
  endtask

  task automatic test_remainder();
    send(1'b0, 16'd7, 17'h0, 17'h1FFFD);
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL rem_n1_valid got %b want 0", out_valid);
    end
    step();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL rem_n2_valid got %b want 1", out_valid);
    end
    checks++;
    if (final_output !== 17'h00004 || out_error !== 1'b0) begin
      errors++;
      $display("FAIL rem_fix got %h/%b want 00004/0", final_output, out_error);
    end
    pop();
    send(1'b0, 16'd7, 17'h0, 17'h00005);
    step();
    in_valid = 1'b0;
    step();
    checks++;
    if (final_output !== 17'h00005 || out_error !== 1'b0) begin
      errors++;
      $display("FAIL rem_pos got %h/%b want 00005/0", final_output, out_error);
    end
    pop();
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rem_empty got %0d/%b want 0/0", count, out_valid);
    end
  endtask

  task automatic test_quotient();
    send(1'b1, 16'd3, 17'h00010, 17'h1FFFD);
    step();
    in_valid = 1'b0;
    step();
    checks++;
    if (final_output !== 17'h00010 || out_error !== 1'b0) begin
      errors++;
      $display("FAIL quo got %h/%b want 00010/0", final_output, out_error);
    end
    pop();
  endtask

  task automatic test_div0();
    send(1'b0, 16'd0, 17'h00003, 17'h00005);
    step();
    send(1'b1, 16'd0, 17'h00003, 17'h00005);
    step();
    in_valid = 1'b0;
    step();
    checks++;
    if (count !== 3'd2) begin
      errors++; $display("FAIL div0_count got %0d want 2", count);
    end
    checks++;
    if (final_output !== 17'h1FFFF || out_error !== 1'b1) begin
      errors++;
      $display("FAIL div0_rem got %h/%b want 1ffff/1", final_output, out_error);
    end
    pop();
    checks++;
    if (final_output !== 17'h1FFFF || out_error !== 1'b1) begin
      errors++;
      $display("FAIL div0_quo got %h/%b want 1ffff/1", final_output, out_error);
    end
    pop();
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 5; i++) begin
      send(1'b1, 16'd1, 17'(i), 17'h0);
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    checks++;
    if (count !== 3'd4) begin
      errors++; $display("FAIL ovf_count got %0d want 4", count);
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_flag got %b want 1", overflow);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL ovf_ready got %b want 0", in_ready);
    end
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || final_output !== 17'(i)) begin
        errors++;
        $display("FAIL ovf_drain%0d got %b/%h want 1/%h",
                 i, out_valid, final_output, 17'(i));
      end
      step();
    end
    out_ready = 1'b0;
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL ovf_lost5 got %0d/%b want 0/0", count, out_valid);
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_sticky got %b want 1", overflow);
    end
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_clr got %b want 0", overflow);
    end
  endtask

  task automatic test_full_push_pop();
    for (int i = 10; i <= 13; i++) begin
      send(1'b1, 16'd1, 17'(i), 17'h0);
      step();
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (count !== 3'd4 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_fill got %0d/%b want 4/0", count, overflow);
    end
    send(1'b1, 16'd1, 17'd14, 17'h0);
    step();
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (count !== 3'd4) begin
      errors++; $display("FAIL full_pp_count got %0d want 4", count);
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL full_pp_ovf got %b want 0", overflow);
    end
    checks++;
    if (final_output !== 17'd11) begin
      errors++; $display("FAIL full_pp_head got %h want 0000b", final_output);
    end
    send(1'b1, 16'd1, 17'd15, 17'h0);
    step();
    in_valid = 1'b0;
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    checks++;
    if (overflow !== 1'b1 || count !== 3'd4) begin
      errors++;
      $display("FAIL set_clr got %b/%0d want 1/4", overflow, count);
    end
    out_ready = 1'b1;
    for (int i = 11; i <= 14; i++) begin
      checks++;
      if (final_output !== 17'(i)) begin
        errors++;
        $display("FAIL full_drain%0d got %h want %h", i, final_output, 17'(i));
      end
      step();
    end
    out_ready = 1'b0;
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int i = 1; i <= 5; i++) begin
      send(1'b1, 16'd1, 17'(i + 20), 17'h0);
      step();
    end
    in_valid = 1'b0;
    step();
    out_ready = 1'b1;
    step();
    send(1'b1, 16'd1, 17'd30, 17'h0);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL mid_valid got %b want 0", out_valid);
    end
    checks++;
    if (count !== 3'd0) begin
      errors++; $display("FAIL mid_count got %0d want 0", count);
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL mid_ovf got %b want 0", overflow);
    end
    checks++;
    if (final_output !== 17'h0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_out got %h/%b want 0/1", final_output, in_ready);
    end
    step();
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    step();
    step();
    step();
    checks++;
    if (out_valid !== 1'b0 || count !== 3'd0) begin
      errors++;
      $display("FAIL mid_after got %b/%0d want 0/0", out_valid, count);
    end
  endtask

  initial begin
    test_reset();
    test_remainder();
    test_quotient();
    test_div0();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
